// File: rtl/button_event_pkg.sv
// Shared types and defaults for the button event front-end.
package button_event_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int HOLD_THRESHOLD_DEF  = 149_999_999;

    localparam int BTN_START = 0;
    localparam int BTN_HOLD  = 1;
    localparam int BTN_STOP  = 2;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: synchronizer, debounce counter and press-detect FSM.
// The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module btn_debounce
    import button_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_async,
    output logic       level,
    output logic       rise_pulse,
    output btn_state_t state
);

    localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_db_cnt;
    btn_state_t             r_state;
    btn_state_t             w_state_next;
    logic                   r_rise;
    logic                   w_sync_q;
    logic                   w_level;
    logic                   w_done;

    assign w_sync_q = r_sync[SYNC_STAGES-1];
    assign w_level  = (r_state == PRESSED) || (r_state == RELEASE_WAIT);
    assign w_done   = (r_db_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_async};
        end
    end

    // Any sample that agrees with the current level restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db_cnt <= '0;
        end else if (w_sync_q == w_level) begin
            r_db_cnt <= '0;
        end else if (w_done) begin
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:         if (w_sync_q) w_state_next = PRESS_WAIT;
            PRESS_WAIT:   if (!w_sync_q) w_state_next = IDLE;
                          else if (w_done) w_state_next = PRESSED;
            PRESSED:      if (!w_sync_q) w_state_next = RELEASE_WAIT;
            RELEASE_WAIT: if (w_sync_q) w_state_next = PRESSED;
                          else if (w_done) w_state_next = IDLE;
            default:      w_state_next = IDLE;
        endcase
    end

    // Bouncing back from RELEASE_WAIT into PRESSED is not a new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_rise  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rise  <= (r_state == PRESS_WAIT) && (w_state_next == PRESSED);
        end
    end

    assign level      = w_level;
    assign rise_pulse = r_rise;
    assign state      = r_state;

endmodule

// File: rtl/button_event_gen.sv
// Debounced start/hold/stop press events plus a saturating hold-duration
// count for the hold button, feeding the counter state machine.
module button_event_gen
    import button_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_WIDTH      = 28,
    parameter int HOLD_THRESHOLD  = HOLD_THRESHOLD_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            btn_raw,
    output logic [2:0]            btn_level,
    output logic                  t1,
    output logic                  t2,
    output logic                  t3,
    output logic [HOLD_WIDTH-1:0] count_hold,
    output logic                  hold_long,
    output logic [5:0]            dbg_state
);

    localparam logic [HOLD_WIDTH-1:0] HOLD_THR = HOLD_WIDTH'(HOLD_THRESHOLD);

    logic [2:0]            w_rise;
    btn_state_t            w_state [3];
    logic [HOLD_WIDTH-1:0] r_count_hold;
    logic [HOLD_WIDTH-1:0] w_count_next;
    logic                  r_hold_long;

    for (genvar i = 0; i < 3; i++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_debounce (
            .clk       (clk),
            .reset     (reset),
            .btn_async (btn_raw[i]),
            .level     (btn_level[i]),
            .rise_pulse(w_rise[i]),
            .state     (w_state[i])
        );
    end

    assign t1 = w_rise[BTN_START];
    assign t2 = w_rise[BTN_HOLD];
    assign t3 = w_rise[BTN_STOP];

    assign dbg_state = {w_state[BTN_STOP], w_state[BTN_HOLD], w_state[BTN_START]};

    // Uses the pre-edge level, so the count reads 0 on the cycle the level rises.
    always_comb begin
        w_count_next = '0;
        if (btn_level[BTN_HOLD]) begin
            w_count_next = (&r_count_hold) ? r_count_hold : r_count_hold + HOLD_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_hold <= '0;
            r_hold_long  <= 1'b0;
        end else begin
            r_count_hold <= w_count_next;
            r_hold_long  <= (w_count_next >= HOLD_THR);
        end
    end

    assign count_hold = r_count_hold;
    assign hold_long  = r_hold_long;

endmodule

// File: tb/tb_button_event_gen.sv
// Self-checking bench for button_event_gen: phase table, hand-written corner
// sequences and randomized stimulus against a run-length reference model.
module tb_button_event_gen;

  localparam int D        = 4;
  localparam int S        = 2;
  localparam int HW       = 8;
  localparam int TH       = 10;
  localparam int HOLD_MAX = (1 << HW) - 1;

  typedef struct {
    logic [2:0] raw;
    int         cycles;
    int         exp_n1;
    int         exp_n2;
    int         exp_n3;
    logic [2:0] exp_level;
  } phase_t;

  logic          clk;
  logic          reset;
  logic [2:0]    btn_raw;
  logic [2:0]    btn_level;
  logic          t1;
  logic          t2;
  logic          t3;
  logic [HW-1:0] count_hold;
  logic          hold_long;
  logic [5:0]    dbg_state;

  // reference model state
  logic [2:0] m_pipe [S];
  int         m_run [3];
  logic [2:0] m_level;
  logic [2:0] m_pulse;
  int         m_hold;
  logic       m_hold_long;

  int         n_cmp;
  int         n_fail;
  int         cyc;
  int         n_t [3];
  logic [2:0] obs_t;

  button_event_gen #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES    (S),
    .HOLD_WIDTH     (HW),
    .HOLD_THRESHOLD (TH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .t1        (t1),
    .t2        (t2),
    .t3        (t3),
    .count_hold(count_hold),
    .hold_long (hold_long),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic tick();
    logic [2:0] old_level;
    logic       sq;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < S; i++) m_pipe[i] = '0;
      for (int c = 0; c < 3; c++) m_run[c] = 0;
      m_level     = '0;
      m_pulse     = '0;
      m_hold      = 0;
      m_hold_long = 1'b0;
    end else begin
      old_level = m_level;
      m_pulse   = '0;
      for (int c = 0; c < 3; c++) begin
        sq = m_pipe[S-1][c];
        if (sq != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_level[c] = sq;
            m_run[c]   = 0;
            m_pulse[c] = sq;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_hold      = old_level[1] ? ((m_hold < HOLD_MAX) ? m_hold + 1 : HOLD_MAX) : 0;
      m_hold_long = (m_hold >= TH);
      for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = btn_raw;
    end
    cyc++;
    @(negedge clk);
    obs_t = {t3, t2, t1};
    for (int c = 0; c < 3; c++) if (obs_t[c]) n_t[c]++;
    check("model_level", {29'd0, btn_level}, {29'd0, m_level});
    check("model_pulse", {29'd0, obs_t}, {29'd0, m_pulse});
    check("model_count_hold", {24'd0, count_hold}, m_hold);
    check("model_hold_long", {31'd0, hold_long}, {31'd0, m_hold_long});
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 3; c++) n_t[c] = 0;
  endtask

  initial begin
    phase_t tbl [8];
    int     k_hit;
    int     k1;
    int     k3;
    int     first_cnt;
    int     thr_cnt;
    int     max_cnt;
    logic   prev_long;

    n_cmp   = 0;
    n_fail  = 0;
    cyc     = 0;
    reset   = 1'b1;
    btn_raw = 3'b000;
    clear_counts();

    tbl[0] = '{3'b000, 10, 0, 0, 0, 3'b000};
    tbl[1] = '{3'b001, 20, 1, 0, 0, 3'b001};
    tbl[2] = '{3'b000, 20, 0, 0, 0, 3'b000};
    tbl[3] = '{3'b100,  3, 0, 0, 0, 3'b000};
    tbl[4] = '{3'b000, 10, 0, 0, 0, 3'b000};
    tbl[5] = '{3'b111, 12, 1, 1, 1, 3'b111};
    tbl[6] = '{3'b010, 12, 0, 0, 0, 3'b010};
    tbl[7] = '{3'b000, 12, 0, 0, 0, 3'b000};

    // reset state
    repeat (3) tick();
    check("reset_level", {29'd0, btn_level}, 32'd0);
    check("reset_pulses", {29'd0, t3, t2, t1}, 32'd0);
    check("reset_count_hold", {24'd0, count_hold}, 32'd0);
    check("reset_hold_long", {31'd0, hold_long}, 32'd0);
    reset = 1'b0;

    // phase table
    for (int p = 0; p < 8; p++) begin
      clear_counts();
      btn_raw = tbl[p].raw;
      repeat (tbl[p].cycles) tick();
      check($sformatf("tbl%0d_n_t1", p), n_t[0], tbl[p].exp_n1);
      check($sformatf("tbl%0d_n_t2", p), n_t[1], tbl[p].exp_n2);
      check($sformatf("tbl%0d_n_t3", p), n_t[2], tbl[p].exp_n3);
      check($sformatf("tbl%0d_level", p), {29'd0, btn_level}, {29'd0, tbl[p].exp_level});
    end

    // clean press and release latency
    clear_counts();
    btn_raw = 3'b001;
    k_hit = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (obs_t[0] && k_hit == 0) k_hit = k;
    end
    check("press_latency", k_hit, 6);
    check("press_count", n_t[0], 1);
    check("press_level", {31'd0, btn_level[0]}, 32'd1);
    clear_counts();
    btn_raw = 3'b000;
    k_hit = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (!btn_level[0] && k_hit == 0) k_hit = k;
    end
    check("release_latency", k_hit, 6);
    check("release_pulses", n_t[0] + n_t[1] + n_t[2], 0);

    // bounce on button 2, then stable high
    clear_counts();
    for (int i = 0; i < 12; i++) begin
      btn_raw = (((i / 2) % 2) == 0) ? 3'b010 : 3'b000;
      tick();
    end
    btn_raw = 3'b010;
    k_hit = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (obs_t[1] && k_hit == 0) k_hit = k;
    end
    check("bounce_latency", k_hit, 6);
    check("bounce_count", n_t[1], 1);
    btn_raw = 3'b000;
    repeat (20) tick();

    // long hold: count_hold ramp, threshold and saturation
    btn_raw   = 3'b010;
    first_cnt = -1;
    thr_cnt   = -1;
    max_cnt   = 0;
    prev_long = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (btn_level[1] && first_cnt < 0) first_cnt = int'(count_hold);
      if (hold_long && !prev_long) thr_cnt = int'(count_hold);
      prev_long = hold_long;
      if (int'(count_hold) > max_cnt) max_cnt = int'(count_hold);
    end
    check("hold_first", first_cnt, 0);
    check("hold_long_rise", thr_cnt, TH);
    check("hold_saturate", max_cnt, HOLD_MAX);
    btn_raw = 3'b000;
    k_hit = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (!btn_level[1] && k_hit == 0) begin
        k_hit = k;
        tick();
        check("hold_clear_count", {24'd0, count_hold}, 32'd0);
        check("hold_clear_long", {31'd0, hold_long}, 32'd0);
      end
    end
    check("hold_release_latency", k_hit, 6);

    // simultaneous start and stop
    clear_counts();
    btn_raw = 3'b101;
    k1 = 0;
    k3 = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (obs_t[0] && k1 == 0) k1 = k;
      if (obs_t[2] && k3 == 0) k3 = k;
    end
    check("simul_t1", k1, 6);
    check("simul_t3", k3, 6);
    check("simul_t2", n_t[1], 0);
    btn_raw = 3'b000;
    repeat (12) tick();

    // reset mid-debounce with buttons held
    btn_raw = 3'b010;
    repeat (12) tick();
    btn_raw = 3'b011;
    repeat (3) tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("midrst_level", {29'd0, btn_level}, 32'd0);
      check("midrst_pulses", {29'd0, obs_t}, 32'd0);
      check("midrst_count_hold", {24'd0, count_hold}, 32'd0);
      check("midrst_hold_long", {31'd0, hold_long}, 32'd0);
    end
    reset = 1'b0;
    clear_counts();
    k_hit = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (obs_t[0] && k_hit == 0) k_hit = k;
    end
    check("midrst_t1_latency", k_hit, 6);
    check("midrst_t1_count", n_t[0], 1);
    btn_raw = 3'b000;
    repeat (12) tick();

    // randomized stimulus with occasional one-cycle resets
    for (int s = 0; s < 250; s++) begin
      btn_raw = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) reset = 1'b1;
      repeat ($urandom_range(1, 12)) begin
        tick();
        reset = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
